fetch_unit: RTL



---
 rtl/fetch_unit.sv | 144 ++++++++++++++
 1 files changed

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: PC generation, credit-limited imem requests,
// response queue with bypass, redirect with stale-response drop, IF/ID register.
module fetch_unit #(
  parameter int unsigned     XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = '0,
  parameter int unsigned     QDEPTH   = 4,
  parameter logic [31:0]     NOP      = 32'h0000_0013
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            stall_F,
  input  logic            flush_D,
  input  logic            PC_src_D,
  input  logic [XLEN-1:0] PC_target_D,
  output logic            imem_req_valid,
  input  logic            imem_req_ready,
  output logic [XLEN-1:0] imem_req_addr,
  input  logic            imem_rsp_valid,
  input  logic [31:0]     imem_rsp_data,
  output logic [31:0]     instr_D,
  output logic [XLEN-1:0] PC_D,
  output logic [XLEN-1:0] PC_plus4_D,
  output logic            valid_D
);

  localparam int unsigned     CW      = $clog2(QDEPTH) + 1;
  localparam int unsigned     PW      = $clog2(QDEPTH);
  localparam logic [XLEN-1:0] PC_STEP = XLEN'(32'd4);

  logic [XLEN-1:0] fetch_pc_q, fetch_pc_d;
  logic [XLEN-1:0] rsp_pc_q, rsp_pc_d;
  logic [CW-1:0]   out_cnt_q, out_cnt_d;
  logic [CW-1:0]   drop_cnt_q, drop_cnt_d;
  logic [CW-1:0]   q_cnt_q, q_cnt_d;
  logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [31:0]     q_instr_q [QDEPTH];
  logic [XLEN-1:0] q_pc_q    [QDEPTH];
  logic [31:0]     if_instr_q, if_instr_d;
  logic [XLEN-1:0] if_pc_q, if_pc_d;
  logic            if_valid_q, if_valid_d;

  logic [CW:0] credit_used;
  logic        issue, dropping, keep, advance, pop, bypass, push;

  assign credit_used    = {1'b0, out_cnt_q} + {1'b0, q_cnt_q};
  assign imem_req_valid = rst_n & ~PC_src_D & (credit_used < (CW+1)'(QDEPTH));
  assign imem_req_addr  = fetch_pc_q;
  assign issue          = imem_req_valid & imem_req_ready;
  assign dropping       = (drop_cnt_q != '0);
  // A response landing in the redirect cycle belongs to the old path.
  assign keep           = imem_rsp_valid & ~dropping & ~PC_src_D;
  assign advance        = ~stall_F & ~flush_D;
  assign pop            = advance & ~PC_src_D & (q_cnt_q != '0);
  assign bypass         = advance & (q_cnt_q == '0) & keep;
  assign push           = keep & ~bypass;

  always_comb begin
    fetch_pc_d = fetch_pc_q;
    rsp_pc_d   = rsp_pc_q;
    out_cnt_d  = out_cnt_q + CW'(issue) - CW'(imem_rsp_valid);
    drop_cnt_d = drop_cnt_q;
    rd_ptr_d   = rd_ptr_q;
    wr_ptr_d   = wr_ptr_q;
    q_cnt_d    = q_cnt_q;
    if (PC_src_D) begin
      fetch_pc_d = PC_target_D;
      rsp_pc_d   = PC_target_D;
      drop_cnt_d = out_cnt_q - CW'(imem_rsp_valid);
      rd_ptr_d   = '0;
      wr_ptr_d   = '0;
      q_cnt_d    = '0;
    end else begin
      if (issue)                       fetch_pc_d = fetch_pc_q + PC_STEP;
      if (keep)                        rsp_pc_d   = rsp_pc_q + PC_STEP;
      if (imem_rsp_valid && dropping)  drop_cnt_d = drop_cnt_q - CW'(1);
      rd_ptr_d = rd_ptr_q + PW'(pop);
      wr_ptr_d = wr_ptr_q + PW'(push);
      q_cnt_d  = q_cnt_q + CW'(push) - CW'(pop);
    end
  end

  always_comb begin
    if_instr_d = if_instr_q;
    if_pc_d    = if_pc_q;
    if_valid_d = if_valid_q;
    if (flush_D) begin
      if_instr_d = NOP;
      if_valid_d = 1'b0;
    end else if (!stall_F) begin
      if (pop) begin
        if_instr_d = q_instr_q[rd_ptr_q];
        if_pc_d    = q_pc_q[rd_ptr_q];
        if_valid_d = 1'b1;
      end else if (bypass) begin
        if_instr_d = imem_rsp_data;
        if_pc_d    = rsp_pc_q;
        if_valid_d = 1'b1;
      end else begin
        if_instr_d = NOP;
        if_valid_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      fetch_pc_q <= RESET_PC;
      rsp_pc_q   <= RESET_PC;
      out_cnt_q  <= '0;
      drop_cnt_q <= '0;
      q_cnt_q    <= '0;
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      if_instr_q <= NOP;
      if_pc_q    <= '0;
      if_valid_q <= 1'b0;
    end else begin
      fetch_pc_q <= fetch_pc_d;
      rsp_pc_q   <= rsp_pc_d;
      out_cnt_q  <= out_cnt_d;
      drop_cnt_q <= drop_cnt_d;
      q_cnt_q    <= q_cnt_d;
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
      if_instr_q <= if_instr_d;
      if_pc_q    <= if_pc_d;
      if_valid_q <= if_valid_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      q_instr_q[wr_ptr_q] <= imem_rsp_data;
      q_pc_q[wr_ptr_q]    <= rsp_pc_q;
    end
  end

  assign instr_D    = if_instr_q;
  assign PC_D       = if_pc_q;
  assign PC_plus4_D = if_pc_q + PC_STEP;
  assign valid_D    = if_valid_q;

endmodule
